// File: rtl/disp_scan_arbiter.sv
// disp_scan_arbiter
// Multiplexed four-digit display scanner shared between two sources.
// src0 owns the display by default. src1 may request ownership, and the
// display then passes through a fully blanked frame on every handover.
// All ownership changes happen only on frame boundaries.
// Optional feature: define DISP_SCAN_DEADTIME_EN to blank the first DEADTIME
// cycles of every digit slot, which suppresses ghosting between digits.
module disp_scan_arbiter #(
  parameter int REFRESH_COUNT = 100000,
  parameter int DEADTIME      = 1000,
  parameter int HOLD_FRAMES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] src0_dig_0,
  input  logic [7:0] src0_dig_1,
  input  logic [7:0] src0_dig_2,
  input  logic [7:0] src0_dig_3,
  input  logic       src1_req,
  input  logic [7:0] src1_dig_0,
  input  logic [7:0] src1_dig_1,
  input  logic [7:0] src1_dig_2,
  input  logic [7:0] src1_dig_3,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       src1_grant
);

  // The refresh counter is sized for the largest legal REFRESH_COUNT (2^20).
  localparam logic [19:0] REF_LAST  = 20'(REFRESH_COUNT - 1);
  localparam logic [19:0] DEAD_CYC  = 20'(DEADTIME);
  localparam logic [7:0]  HOLD_MAX  = 8'(HOLD_FRAMES);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

`ifdef DISP_SCAN_DEADTIME_EN
  localparam logic DEAD_EN = 1'b1;
`else
  localparam logic DEAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OWN0  = 2'd0,
    BLANK = 2'd1,
    OWN1  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [19:0] r_refCnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_holdCnt;
  logic        w_slotEnd;
  logic        w_frameEnd;
  logic        w_blankSlot;
  logic [7:0]  w_src0Dig;
  logic [7:0]  w_src1Dig;
  logic [3:0]  w_anNext;
  logic [7:0]  w_segNext;
  logic        w_grantNext;
  logic [3:0]  r_an;
  logic [7:0]  r_seg;
  logic        r_grant;

  assign w_slotEnd  = (r_refCnt == REF_LAST);
  assign w_frameEnd = w_slotEnd && (r_idx == 2'd3);

  // Deadtime only exists when the feature is compiled in; otherwise the
  // comparison is masked off and every slot is driven for its full length.
  assign w_blankSlot = DEAD_EN && (r_refCnt < DEAD_CYC);

  // Refresh counter and digit index: each slot lasts REFRESH_COUNT cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_refCnt <= '0;
      r_idx    <= '0;
    end else if (w_slotEnd) begin
      r_refCnt <= '0;
      r_idx    <= r_idx + 2'd1;
    end else begin
      r_refCnt <= r_refCnt + 20'd1;
    end
  end

  // Ownership state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= OWN0;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: src1_req is only looked at on the frame-boundary cycle.
  always_comb begin
    w_stateNext = r_state;
    if (w_frameEnd) begin
      unique case (r_state)
        OWN0: begin
          if (src1_req) begin
            w_stateNext = BLANK;
          end
        end
        BLANK: begin
          w_stateNext = src1_req ? OWN1 : OWN0;
        end
        OWN1: begin
          if ((r_holdCnt >= HOLD_LAST) && !src1_req) begin
            w_stateNext = BLANK;
          end
        end
        default: begin
          w_stateNext = OWN0;
        end
      endcase
    end
  end

  // Hold counter: sits at zero outside OWN1, so it starts from zero on entry,
  // then counts completed OWN1 frames and saturates at HOLD_FRAMES.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_holdCnt <= '0;
    end else if (r_state != OWN1) begin
      r_holdCnt <= '0;
    end else if (w_frameEnd && (r_holdCnt < HOLD_MAX)) begin
      r_holdCnt <= r_holdCnt + 8'd1;
    end
  end

  // Select the current digit pattern from each source.
  always_comb begin
    w_src0Dig = src0_dig_0;
    w_src1Dig = src1_dig_0;
    unique case (r_idx)
      2'd0: begin
        w_src0Dig = src0_dig_0;
        w_src1Dig = src1_dig_0;
      end
      2'd1: begin
        w_src0Dig = src0_dig_1;
        w_src1Dig = src1_dig_1;
      end
      2'd2: begin
        w_src0Dig = src0_dig_2;
        w_src1Dig = src1_dig_2;
      end
      default: begin
        w_src0Dig = src0_dig_3;
        w_src1Dig = src1_dig_3;
      end
    endcase
  end

  // Output decode: drive the owner's digit, or blank during handover/deadtime.
  always_comb begin
    w_anNext    = 4'b1111;
    w_segNext   = 8'hFF;
    w_grantNext = (w_stateNext == OWN1);
    unique case (r_state)
      OWN0: begin
        w_anNext  = ~(4'b0001 << r_idx);
        w_segNext = w_src0Dig;
      end
      OWN1: begin
        w_anNext  = ~(4'b0001 << r_idx);
        w_segNext = w_src1Dig;
      end
      default: begin
        w_anNext  = 4'b1111;
        w_segNext = 8'hFF;
      end
    endcase
    if (w_blankSlot) begin
      w_anNext  = 4'b1111;
      w_segNext = 8'hFF;
    end
  end

  // Output register: glitch-free pins, grant aligned with the OWN1 state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_an    <= 4'b1111;
      r_seg   <= 8'hFF;
      r_grant <= 1'b0;
    end else begin
      r_an    <= w_anNext;
      r_seg   <= w_segNext;
      r_grant <= w_grantNext;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign src1_grant = r_grant;

endmodule
